// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares the single-port data RAM between the CPU data port (M0) and a
//   second master (M1: DMA / debug loader). Ownership is a two-state FSM that
//   parks on M0, so CPU accesses see zero wait states while M1 is idle. A hold
//   counter bounds how many consecutive beats the current owner may take
//   while the other master is waiting.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   m0_ce_i/we/addr/sel/data CPU request (one beat per cycle while ce high)
//   m0_data_o, m0_stall_o    CPU read data, stall (beat not accepted)
//   m1_req_i/we/addr/sel/data M1 request (held with payload until ack)
//   m1_data_o, m1_ack_o      M1 read data, beat accepted this cycle
//   s_ce_o/we/addr/sel/data  to data_ram; s_data_i combinational read data
//   dbg_state_o              current owner (0 = M0, 1 = M1)
//
// Handshake: an M0 beat completes in any cycle with m0_ce_i & ~m0_stall_o; an
// M1 beat completes in any cycle with m1_req_i & m1_ack_o. A stalled or
// unacknowledged master holds its payload unchanged. Read data is returned in
// the same cycle as the completing beat; writes commit at the next clock edge.
// Ownership changes are registered, so a grant change takes effect one cycle
// after the condition that causes it.
module data_ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ce_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_stall_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              s_ce_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [3:0]        s_sel_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              dbg_state_o
);

  localparam logic [0:0] OWN0 = 1'b0;
  localparam logic [0:0] OWN1 = 1'b1;

  localparam int          HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [HW-1:0]     r_hold_cnt;
  logic [HW-1:0]     w_hold_nxt;
  logic              w_hold_last;
  logic              w_own1;

  logic              w_ce;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_sel;
  logic [DATA_W-1:0] w_wdata;

  assign w_hold_last = (r_hold_cnt == HOLD_LAST);
  assign w_own1      = (r_state == OWN1);

  // The counter only runs while both masters want the RAM; it measures how
  // long the waiting master has been kept out and resets on every handover.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = '0;
    case (r_state)
      OWN0: begin
        if (m1_req_i && (!m0_ce_i || w_hold_last)) begin
          w_state_nxt = OWN1;
        end else if (m1_req_i && m0_ce_i) begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end
      end
      OWN1: begin
        if (!m1_req_i || (m0_ce_i && w_hold_last)) begin
          w_state_nxt = OWN0;
        end else if (m0_ce_i) begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end
      end
      default: begin
        w_state_nxt = OWN0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= OWN0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Slave mux follows the registered owner; the write strobe is qualified by
  // the chosen request so the RAM never sees we without ce.
  always_comb begin
    if (w_own1) begin
      w_ce    = m1_req_i;
      w_we    = m1_we_i & m1_req_i;
      w_addr  = m1_addr_i;
      w_sel   = m1_sel_i;
      w_wdata = m1_data_i;
    end else begin
      w_ce    = m0_ce_i;
      w_we    = m0_we_i & m0_ce_i;
      w_addr  = m0_addr_i;
      w_sel   = m0_sel_i;
      w_wdata = m0_data_i;
    end
  end

  // Every output is gated by rst so a reset arriving mid-beat removes the
  // strobe immediately and nothing is written at the following edge.
  assign s_ce_o      = rst & w_ce;
  assign s_we_o      = rst & w_we;
  assign s_addr_o    = {ADDR_W{rst}} & w_addr;
  assign s_sel_o     = {4{rst}} & w_sel;
  assign s_data_o    = {DATA_W{rst}} & w_wdata;
  assign m0_data_o   = {DATA_W{rst}} & s_data_i;
  assign m1_data_o   = {DATA_W{rst}} & s_data_i;
  assign m0_stall_o  = rst & m0_ce_i & w_own1;
  assign m1_ack_o    = rst & m1_req_i & w_own1;
  assign dbg_state_o = r_state[0];

endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_ce_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic [3:0]  m0_sel_i;
  logic        m0_stall_o;
  logic        m1_req_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o;
  logic        s_ce_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic [3:0]  s_sel_o;
  logic        dbg_state_o;

  logic [31:0] mem [0:255];
  logic [31:0] exp_m0_q[$];
  logic [31:0] exp_m1_q[$];
  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .m0_ce_i(m0_ce_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_sel_i(m0_sel_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_stall_o(m0_stall_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_sel_i(m1_sel_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o),
    .s_ce_o(s_ce_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_sel_o(s_sel_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .dbg_state_o(dbg_state_o)
  );

  // data_ram model: combinational read, byte-lane write at the clock edge
  assign s_data_i = mem[s_addr_o[9:2]];
  always @(posedge clk) begin
    if (s_ce_o && s_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (s_sel_o[b]) mem[s_addr_o[9:2]][8*b +: 8] <= s_data_o[8*b +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic m0_set(input logic ce, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sel);
    m0_ce_i = ce; m0_we_i = we; m0_addr_i = a; m0_data_i = d; m0_sel_i = sel;
  endtask

  task automatic m1_set(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sel);
    m1_req_i = req; m1_we_i = we; m1_addr_i = a; m1_data_i = d; m1_sel_i = sel;
  endtask

  function automatic logic [31:0] t1_data(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  // scoreboard monitor: pops an expected value on every completed read beat
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("we_without_ce", {31'd0, s_we_o & ~s_ce_o}, 32'd0);
      if (m0_ce_i && !m0_stall_o) begin
        chk("m0_s_ce", {31'd0, s_ce_o}, 32'd1);
        chk("m0_s_addr", s_addr_o, m0_addr_i);
        if (m0_we_i) begin
          chk("m0_s_wdata", s_data_o, m0_data_i);
        end else if (exp_m0_q.size() == 0) begin
          chk("m0_unexpected_read", 32'd1, 32'd0);
        end else begin
          chk("m0_rdata", m0_data_o, exp_m0_q.pop_front());
        end
      end
      if (m1_ack_o) begin
        chk("m1_s_addr", s_addr_o, m1_addr_i);
        if (m1_we_i) begin
          chk("m1_s_wdata", s_data_o, m1_data_i);
          chk("m1_s_sel", {28'd0, s_sel_o}, {28'd0, m1_sel_i});
        end else if (exp_m1_q.size() == 0) begin
          chk("m1_unexpected_read", 32'd1, 32'd0);
        end else begin
          chk("m1_rdata", m1_data_o, exp_m1_q.pop_front());
        end
      end
    end
  end

  int m0_n, m1_n, m0_issued;
  logic w0, w1, e0, e1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst = 1'b0;
    m0_set(1'b1, 1'b1, 32'h48, 32'hFFFF_FFFF, 4'hF);
    m1_set(1'b1, 1'b1, 32'h48, 32'hEEEE_EEEE, 4'hF);
    #12;
    chk("rst_s_ce", {31'd0, s_ce_o}, 32'd0);
    chk("rst_s_we", {31'd0, s_we_o}, 32'd0);
    chk("rst_stall", {31'd0, m0_stall_o}, 32'd0);
    chk("rst_ack", {31'd0, m1_ack_o}, 32'd0);
    chk("rst_s_addr", s_addr_o, 32'd0);
    chk("rst_s_data", s_data_o, 32'd0);
    chk("rst_state", {31'd0, dbg_state_o}, 32'd0);
    m0_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    m1_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    tick();
    rst = 1'b1;
    tick(); tick();

    // M0 only: back-to-back stores then loads, never stalled
    for (int i = 0; i < 5; i++) begin
      m0_set(1'b1, 1'b1, 32'h100 + 32'(4*i), t1_data(i), 4'hF);
      at_neg(); chk("t1_st_stall", {31'd0, m0_stall_o}, 32'd0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      m0_set(1'b1, 1'b0, 32'h100 + 32'(4*i), 32'd0, 4'hF);
      exp_m0_q.push_back(t1_data(i));
      at_neg(); chk("t1_ld_stall", {31'd0, m0_stall_o}, 32'd0);
      tick();
    end
    m0_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    repeat (3) tick();

    // M1 only: one-cycle grant latency, single ack per beat
    m1_set(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    at_neg(); chk("t2_ack_n", {31'd0, m1_ack_o}, 32'd0);
    tick();
    at_neg(); chk("t2_ack_n1", {31'd0, m1_ack_o}, 32'd1);
    chk("t2_state_own1", {31'd0, dbg_state_o}, 32'd1);
    tick();
    m1_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    at_neg(); chk("t2_ack_drop", {31'd0, m1_ack_o}, 32'd0);
    tick();
    chk("t2_state_own0", {31'd0, dbg_state_o}, 32'd0);
    m1_set(1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
    exp_m1_q.push_back(32'hDEAD_BEEF);
    at_neg(); chk("t2_rd_ack_n", {31'd0, m1_ack_o}, 32'd0);
    tick();
    at_neg(); chk("t2_rd_ack_n1", {31'd0, m1_ack_o}, 32'd1);
    tick();
    m1_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    tick(); tick();

    // simultaneous first request: M0 first, M1 one cycle after M0 drops
    m0_set(1'b1, 1'b0, 32'h104, 32'd0, 4'hF);
    exp_m0_q.push_back(t1_data(1));
    m1_set(1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
    exp_m1_q.push_back(32'hDEAD_BEEF);
    at_neg(); chk("t4_stall", {31'd0, m0_stall_o}, 32'd0);
    chk("t4_ack0", {31'd0, m1_ack_o}, 32'd0);
    tick();
    m0_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    at_neg(); chk("t4_ack1", {31'd0, m1_ack_o}, 32'd0);
    tick();
    at_neg(); chk("t4_ack2", {31'd0, m1_ack_o}, 32'd1);
    tick();
    m1_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    at_neg(); chk("t4_ack3", {31'd0, m1_ack_o}, 32'd0);
    tick(); tick();

    // M1 partial write while M0 stalled
    m1_set(1'b1, 1'b1, 32'h100, 32'hAAAA_5555, 4'b0011);
    at_neg(); chk("t6_ack0", {31'd0, m1_ack_o}, 32'd0);
    tick();
    m0_set(1'b1, 1'b0, 32'h100, 32'd0, 4'hF);
    exp_m0_q.push_back(32'hC0DE_5555);
    at_neg(); chk("t6_ack1", {31'd0, m1_ack_o}, 32'd1);
    chk("t6_stall1", {31'd0, m0_stall_o}, 32'd1);
    tick();
    m1_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    at_neg(); chk("t6_ack_drop", {31'd0, m1_ack_o}, 32'd0);
    chk("t6_stall_drop", {31'd0, m0_stall_o}, 32'd1);
    tick();
    at_neg(); chk("t6_stall_release", {31'd0, m0_stall_o}, 32'd0);
    tick();
    m0_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    tick();

    // contention: 4 M0 beats, 4 M1 beats, alternating
    m0_n = 0; m1_n = 0; m0_issued = -1;
    for (int c = 0; c < 20; c++) begin
      if (m0_n < 8) begin
        m0_set(1'b1, 1'b0, 32'h104 + 32'(4*(m0_n % 4)), 32'd0, 4'hF);
        if (m0_issued != m0_n) begin
          exp_m0_q.push_back(t1_data((m0_n % 4) + 1));
          m0_issued = m0_n;
        end
      end else begin
        m0_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      end
      if (m1_n < 8) m1_set(1'b1, 1'b1, 32'h200 + 32'(4*m1_n), 32'h5000_0000 + 32'(m1_n), 4'hF);
      else          m1_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      at_neg();
      w0 = m0_ce_i & ~m0_stall_o;
      w1 = m1_ack_o;
      e0 = (c < 4) || (c >= 8 && c < 12);
      e1 = (c >= 4 && c < 8) || (c >= 12 && c < 16);
      chk($sformatf("t3_m0_grant_c%0d", c), {31'd0, w0}, {31'd0, e0});
      chk($sformatf("t3_m1_grant_c%0d", c), {31'd0, w1}, {31'd0, e1});
      if (w0) m0_n++;
      if (w1) m1_n++;
      tick();
    end
    chk("t3_m0_beats", 32'(m0_n), 32'd8);
    chk("t3_m1_beats", 32'(m1_n), 32'd8);
    m0_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    m1_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    tick();

    // reset during an M1 burst
    m1_set(1'b1, 1'b1, 32'h40, 32'h1111_1111, 4'hF);
    at_neg(); chk("t5_ack0", {31'd0, m1_ack_o}, 32'd0);
    tick();
    at_neg(); chk("t5_ack1", {31'd0, m1_ack_o}, 32'd1);
    tick();
    m1_set(1'b1, 1'b1, 32'h44, 32'h2222_2222, 4'hF);
    #1 rst = 1'b0;
    #1;
    chk("t5_s_ce", {31'd0, s_ce_o}, 32'd0);
    chk("t5_s_we", {31'd0, s_we_o}, 32'd0);
    chk("t5_ack", {31'd0, m1_ack_o}, 32'd0);
    chk("t5_s_addr", s_addr_o, 32'd0);
    chk("t5_s_data", s_data_o, 32'd0);
    chk("t5_m1_data", m1_data_o, 32'd0);
    chk("t5_state", {31'd0, dbg_state_o}, 32'd0);
    m1_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t5_state_after", {31'd0, dbg_state_o}, 32'd0);

    // readbacks through M0
    m0_set(1'b1, 1'b0, 32'h40, 32'd0, 4'hF);  exp_m0_q.push_back(32'h1111_1111);
    at_neg(); chk("rb_stall0", {31'd0, m0_stall_o}, 32'd0); tick();
    m0_set(1'b1, 1'b0, 32'h44, 32'd0, 4'hF);  exp_m0_q.push_back(32'h0000_0000);
    at_neg(); chk("rb_stall1", {31'd0, m0_stall_o}, 32'd0); tick();
    m0_set(1'b1, 1'b0, 32'h48, 32'd0, 4'hF);  exp_m0_q.push_back(32'h0000_0000);
    at_neg(); tick();
    m0_set(1'b1, 1'b0, 32'h200, 32'd0, 4'hF); exp_m0_q.push_back(32'h5000_0000);
    at_neg(); tick();
    m0_set(1'b1, 1'b0, 32'h21C, 32'd0, 4'hF); exp_m0_q.push_back(32'h5000_0007);
    at_neg(); tick();
    m0_set(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);

    // bounded drain of the scoreboard
    for (int i = 0; i < 20; i++) begin
      if (exp_m0_q.size() == 0 && exp_m1_q.size() == 0) break;
      tick();
    end
    chk("drain_m0", 32'(exp_m0_q.size()), 32'd0);
    chk("drain_m1", 32'(exp_m1_q.size()), 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
